bram_fifo_ctrl_18k: RTL and testbench

Single-clock first-word-fall-through FIFO controller that drives one half (one write port plus one read port) of the dual 18K block-RAM primitive. It owns the write/read pointers, occupancy counting and a two-entry output prefetch buffer. The buffer hides the RAM's one-cycle read latency so the pop side sees a registered valid/ready stream at full throughput. It sits directly upstream of the RAM half it controls and is instantiated once per half.

---
 rtl/bram_fifo_pkg.sv | 27 ++
 rtl/bram_fifo_prefetch.sv | 71 +++++++
 rtl/bram_fifo_ctrl_18k.sv | 118 +++++++++++
 tb/tb_bram_fifo_ctrl_18k.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_fifo_pkg.sv
// Shared constants for the 18K block-RAM FWFT FIFO controller:
// supported width/depth pairs, depth derivation and prefetch buffer size.
package bram_fifo_pkg;

    // Supported aspect ratios of one 18K half
    localparam int W9_DATA_WIDTH  = 9;
    localparam int W9_ADDR_WIDTH  = 11;
    localparam int W9_DEPTH       = 2048;
    localparam int W18_DATA_WIDTH = 18;
    localparam int W18_ADDR_WIDTH = 10;
    localparam int W18_DEPTH      = 1024;

    // Output-side head + skid entries that hide the RAM read latency
    localparam int PREFETCH_DEPTH = 2;

    // RAM depth follows directly from the address width
    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    // True for the two width/depth pairs the primitive supports
    function automatic bit width_ok(input int data_width, input int addr_width);
        return ((data_width == W9_DATA_WIDTH)  && (addr_width == W9_ADDR_WIDTH)) ||
               ((data_width == W18_DATA_WIDTH) && (addr_width == W18_ADDR_WIDTH));
    endfunction

endpackage

// File: rtl/bram_fifo_prefetch.sv
// Two-entry head/skid output buffer. Captures RAM read data the cycle after
// a read is issued and presents the head word as a registered stream.
module bram_fifo_prefetch
    import bram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 18
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  issue,
    input  logic                  pop_ready,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  pop_valid,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic [1:0]            buf_cnt,
    output logic                  inflight
);

    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] skid;
    logic [1:0]            cnt;
    logic                  pop_fire;

    assign pop_fire  = (cnt != 2'd0) & pop_ready;
    assign pop_valid = (cnt != 2'd0);
    assign pop_data  = head;
    assign buf_cnt   = cnt;

    // A read issued this cycle returns data next cycle; flush drops it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     inflight <= 1'b0;
        else if (flush) inflight <= 1'b0;
        else            inflight <= issue;
    end

    // Returning data fills head first, then skid; a pop shifts skid into head
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            skid <= '0;
            cnt  <= 2'd0;
        end else if (flush) begin
            head <= '0;
            skid <= '0;
            cnt  <= 2'd0;
        end else begin
            case ({inflight, pop_fire})
                2'b10: begin
                    if (cnt == 2'd0) head <= rdata;
                    else             skid <= rdata;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    head <= skid;
                    cnt  <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        head <= rdata;
                    end else begin
                        head <= skid;
                        skid <= rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/bram_fifo_ctrl_18k.sv
// First-word-fall-through FIFO controller for one half of a dual 18K BRAM.
// Owns write/read pointers, RAM occupancy and level flags; the prefetch
// sub-module hides the one-cycle RAM read latency.
// Optional: define BRAM_FIFO_CTRL_ERR_EN for a sticky overflow/underflow flag.
module bram_fifo_ctrl_18k
    import bram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 18,
    parameter int ADDR_WIDTH = 10,
    parameter int AF_LEVEL   = 1020,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clock0,
    input  logic                  RESET_ni,
    input  logic                  FLUSH_i,
    input  logic                  PUSH_VALID_i,
    output logic                  PUSH_READY_o,
    input  logic [DATA_WIDTH-1:0] PUSH_DATA_i,
    output logic                  POP_VALID_o,
    input  logic                  POP_READY_i,
    output logic [DATA_WIDTH-1:0] POP_DATA_o,
    output logic [ADDR_WIDTH+1:0] COUNT_o,
    output logic                  ALMOST_FULL_o,
    output logic                  ALMOST_EMPTY_o,
    output logic                  ERR_o,
    output logic                  WEN_o,
    output logic                  REN_o,
    output logic [ADDR_WIDTH-1:0] WR_ADDR_o,
    output logic [ADDR_WIDTH-1:0] RD_ADDR_o,
    output logic [DATA_WIDTH-1:0] WDATA_o,
    input  logic [DATA_WIDTH-1:0] RDATA_i
);

    localparam int              CW      = ADDR_WIDTH + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(fifo_depth(ADDR_WIDTH));
    localparam logic [CW-1:0]   AF_C    = CW'(AF_LEVEL);
    localparam logic [CW:0]     AE_C    = (CW + 1)'(AE_LEVEL);
    localparam logic [2:0]      PF_C    = 3'(PREFETCH_DEPTH);

    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [CW-1:0]         mem_cnt;
    logic                  full;
    logic                  push_fire;
    logic                  pop_fire;
    logic                  issue;
    logic                  inflight;
    logic [1:0]            buf_cnt;
    logic [2:0]            occ;

    assign full      = (mem_cnt == DEPTH_C);
    assign push_fire = PUSH_VALID_i & ~full & ~FLUSH_i;
    assign pop_fire  = POP_VALID_o & POP_READY_i;
    assign occ       = {1'b0, buf_cnt} + {2'b00, inflight};
    // Issue only if the returning word is guaranteed a buffer slot
    assign issue     = (mem_cnt != '0) & ~FLUSH_i & (occ < (PF_C + {2'b00, pop_fire}));

    assign PUSH_READY_o   = ~full;
    assign WEN_o          = push_fire;
    assign WR_ADDR_o      = wptr;
    assign WDATA_o        = PUSH_DATA_i;
    assign REN_o          = issue;
    assign RD_ADDR_o      = rptr;
    assign COUNT_o        = {1'b0, mem_cnt} + {{CW{1'b0}}, inflight} + {{ADDR_WIDTH{1'b0}}, buf_cnt};
    assign ALMOST_FULL_o  = (mem_cnt >= AF_C);
    assign ALMOST_EMPTY_o = (COUNT_o <= AE_C);

    // Pointers wrap naturally at 2^ADDR_WIDTH; occupancy tracks RAM words not yet read
    always_ff @(posedge clock0 or negedge RESET_ni) begin
        if (!RESET_ni) begin
            wptr    <= '0;
            rptr    <= '0;
            mem_cnt <= '0;
        end else if (FLUSH_i) begin
            wptr    <= '0;
            rptr    <= '0;
            mem_cnt <= '0;
        end else begin
            if (push_fire) wptr <= wptr + 1'b1;
            if (issue)     rptr <= rptr + 1'b1;
            mem_cnt <= mem_cnt + {{ADDR_WIDTH{1'b0}}, push_fire} - {{ADDR_WIDTH{1'b0}}, issue};
        end
    end

    bram_fifo_prefetch #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_prefetch (
        .clk       (clock0),
        .rst_n     (RESET_ni),
        .flush     (FLUSH_i),
        .issue     (issue),
        .pop_ready (POP_READY_i),
        .rdata     (RDATA_i),
        .pop_valid (POP_VALID_o),
        .pop_data  (POP_DATA_o),
        .buf_cnt   (buf_cnt),
        .inflight  (inflight)
    );

`ifdef BRAM_FIFO_CTRL_ERR_EN
    logic err;

    // Sticky: push while full or pop request while empty; only flush/reset clear it
    always_ff @(posedge clock0 or negedge RESET_ni) begin
        if (!RESET_ni)
            err <= 1'b0;
        else if (FLUSH_i)
            err <= 1'b0;
        else if ((PUSH_VALID_i & full) | (POP_READY_i & ~POP_VALID_o))
            err <= 1'b1;
    end

    assign ERR_o = err;
`else
    assign ERR_o = 1'b0;
`endif

endmodule

// File: tb/tb_bram_fifo_ctrl_18k.sv
// Self-checking bench for bram_fifo_ctrl_18k: table-driven first-word latency,
// fill/drain, streaming across pointer wrap, flush, error flag, async reset and
// a randomized phase checked against a queue-based reference model.
module tb_bram_fifo_ctrl_18k;

    localparam int DW    = 18;
    localparam int AW    = 10;
    localparam int DEPTH = 1024;

    logic          clock0 = 1'b0;
    logic          RESET_ni;
    logic          FLUSH_i;
    logic          PUSH_VALID_i;
    logic          PUSH_READY_o;
    logic [DW-1:0] PUSH_DATA_i;
    logic          POP_VALID_o;
    logic          POP_READY_i;
    logic [DW-1:0] POP_DATA_o;
    logic [AW+1:0] COUNT_o;
    logic          ALMOST_FULL_o;
    logic          ALMOST_EMPTY_o;
    logic          ERR_o;
    logic          WEN_o;
    logic          REN_o;
    logic [AW-1:0] WR_ADDR_o;
    logic [AW-1:0] RD_ADDR_o;
    logic [DW-1:0] WDATA_o;
    logic [DW-1:0] RDATA_i;

    bram_fifo_ctrl_18k #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .AF_LEVEL   (1020),
        .AE_LEVEL   (2)
    ) dut (
        .clock0         (clock0),
        .RESET_ni       (RESET_ni),
        .FLUSH_i        (FLUSH_i),
        .PUSH_VALID_i   (PUSH_VALID_i),
        .PUSH_READY_o   (PUSH_READY_o),
        .PUSH_DATA_i    (PUSH_DATA_i),
        .POP_VALID_o    (POP_VALID_o),
        .POP_READY_i    (POP_READY_i),
        .POP_DATA_o     (POP_DATA_o),
        .COUNT_o        (COUNT_o),
        .ALMOST_FULL_o  (ALMOST_FULL_o),
        .ALMOST_EMPTY_o (ALMOST_EMPTY_o),
        .ERR_o          (ERR_o),
        .WEN_o          (WEN_o),
        .REN_o          (REN_o),
        .WR_ADDR_o      (WR_ADDR_o),
        .RD_ADDR_o      (RD_ADDR_o),
        .WDATA_o        (WDATA_o),
        .RDATA_i        (RDATA_i)
    );

    always #5 clock0 = ~clock0;

    // Block RAM half: synchronous write, one-cycle registered read
    logic [DW-1:0] ram [0:DEPTH-1];
    always @(posedge clock0) begin
        if (WEN_o) ram[WR_ADDR_o] <= WDATA_o;
        if (REN_o) RDATA_i <= ram[RD_ADDR_o];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Reference model: words in RAM, the one word in flight, buffered words
    logic [DW-1:0] ram_q[$];
    logic [DW-1:0] buf_q[$];
    bit            m_infl;
    logic [DW-1:0] m_infl_d;
    int            m_wa, m_ra;
    bit            m_err;
    bit            m_push_f;
    int            m_total;

    task automatic model_clear();
        ram_q.delete();
        buf_q.delete();
        m_infl = 0;
        m_wa   = 0;
        m_ra   = 0;
        m_err  = 0;
    endtask

    // Apply inputs, then at the falling edge compare and advance the model
    task automatic drive_check(input logic pv, input logic [DW-1:0] pd, input logic pr, input logic fl);
        bit full, pop_f, issue;
        int occ;
        PUSH_VALID_i = pv;
        PUSH_DATA_i  = pd;
        POP_READY_i  = pr;
        FLUSH_i      = fl;
        @(negedge clock0);
        full    = (ram_q.size() == DEPTH);
        m_total = ram_q.size() + int'(m_infl) + buf_q.size();
        chk("push_ready", PUSH_READY_o, !full);
        chk("pop_valid", POP_VALID_o, buf_q.size() > 0);
        if (buf_q.size() > 0) chk("pop_data", POP_DATA_o, buf_q[0]);
        chk("count", COUNT_o, m_total);
        chk("almost_full", ALMOST_FULL_o, ram_q.size() >= 1020);
        chk("almost_empty", ALMOST_EMPTY_o, m_total <= 2);
        chk("err", ERR_o, m_err);
        m_push_f = pv && !full && !fl;
        pop_f    = (buf_q.size() > 0) && pr;
        occ      = buf_q.size() + int'(m_infl) - int'(pop_f);
        issue    = (ram_q.size() > 0) && !fl && (occ < 2);
        chk("wen", WEN_o, m_push_f);
        chk("ren", REN_o, issue);
        if (m_push_f) begin
            chk("wr_addr", WR_ADDR_o, m_wa);
            chk("wdata", WDATA_o, pd);
        end
        if (issue) chk("rd_addr", RD_ADDR_o, m_ra);
`ifdef BRAM_FIFO_CTRL_ERR_EN
        if (fl) m_err = 0;
        else if ((pv && full) || (pr && buf_q.size() == 0)) m_err = 1;
`endif
        if (fl) begin
            ram_q.delete();
            buf_q.delete();
            m_infl = 0;
            m_wa   = 0;
            m_ra   = 0;
        end else begin
            if (pop_f) void'(buf_q.pop_front());
            if (m_infl) buf_q.push_back(m_infl_d);
            m_infl = issue;
            if (issue) begin
                m_infl_d = ram_q.pop_front();
                m_ra     = (m_ra + 1) % DEPTH;
            end
            if (m_push_f) begin
                ram_q.push_back(pd);
                m_wa = (m_wa + 1) % DEPTH;
            end
        end
    endtask

    task automatic finish_cycle();
        @(posedge clock0);
        #1;
    endtask

    task automatic step(input logic pv, input logic [DW-1:0] pd, input logic pr, input logic fl);
        drive_check(pv, pd, pr, fl);
        finish_cycle();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_pop_valid"}, POP_VALID_o, 1'b0);
        chk({tag, "_pop_data"}, POP_DATA_o, '0);
        chk({tag, "_count"}, COUNT_o, '0);
        chk({tag, "_push_ready"}, PUSH_READY_o, 1'b1);
        chk({tag, "_almost_empty"}, ALMOST_EMPTY_o, 1'b1);
        chk({tag, "_almost_full"}, ALMOST_FULL_o, 1'b0);
        chk({tag, "_err"}, ERR_o, 1'b0);
        chk({tag, "_wen"}, WEN_o, 1'b0);
        chk({tag, "_ren"}, REN_o, 1'b0);
        chk({tag, "_wr_addr"}, WR_ADDR_o, '0);
        chk({tag, "_rd_addr"}, RD_ADDR_o, '0);
    endtask

    typedef struct {
        logic          pv;
        logic [DW-1:0] pd;
        logic          pr;
        logic          exp_valid;
        logic [DW-1:0] exp_data;
        logic [AW+1:0] exp_count;
        logic          exp_ren;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int acc, guard, steady_cnt;
        logic exp_err;

        // First-word latency: push at row 0, visible on row 3, popped there
        tbl[0] = '{1'b1, 18'h2A5A3, 1'b0, 1'b0, 18'h0,     12'd0, 1'b0};
        tbl[1] = '{1'b0, 18'h0,     1'b0, 1'b0, 18'h0,     12'd1, 1'b1};
        tbl[2] = '{1'b0, 18'h0,     1'b0, 1'b0, 18'h0,     12'd1, 1'b0};
        tbl[3] = '{1'b0, 18'h0,     1'b1, 1'b1, 18'h2A5A3, 12'd1, 1'b0};
        tbl[4] = '{1'b0, 18'h0,     1'b0, 1'b0, 18'h0,     12'd0, 1'b0};

`ifdef BRAM_FIFO_CTRL_ERR_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif

        RESET_ni     = 1'b0;
        FLUSH_i      = 1'b0;
        PUSH_VALID_i = 1'b0;
        PUSH_DATA_i  = '0;
        POP_READY_i  = 1'b0;
        model_clear();
        repeat (3) @(posedge clock0);
        #1;
        check_reset_values("reset");
        #2 RESET_ni = 1'b1;
        finish_cycle();

        for (int i = 0; i < 5; i++) begin
            drive_check(tbl[i].pv, tbl[i].pd, tbl[i].pr, 1'b0);
            chk($sformatf("tbl%0d_valid", i), POP_VALID_o, tbl[i].exp_valid);
            if (tbl[i].exp_valid) chk($sformatf("tbl%0d_data", i), POP_DATA_o, tbl[i].exp_data);
            chk($sformatf("tbl%0d_count", i), COUNT_o, tbl[i].exp_count);
            chk($sformatf("tbl%0d_ren", i), REN_o, tbl[i].exp_ren);
            finish_cycle();
        end

        // Fill with the consumer stalled: DEPTH words in RAM plus two buffered
        acc   = 0;
        guard = 0;
        while (acc < DEPTH + 2 && guard < DEPTH + 100) begin
            step(1'b1, DW'(acc + 1), 1'b0, 1'b0);
            if (m_push_f) acc++;
            guard++;
        end
        chk("fill_accepted", acc, DEPTH + 2);
        drive_check(1'b1, 18'h3FFFF, 1'b0, 1'b0);
        chk("full_push_ready", PUSH_READY_o, 1'b0);
        chk("full_count", COUNT_o, DEPTH + 2);
        chk("full_almost_full", ALMOST_FULL_o, 1'b1);
        chk("full_wen", WEN_o, 1'b0);
        finish_cycle();
        drive_check(1'b0, '0, 1'b0, 1'b0);
        chk("err_after_overflow", ERR_o, exp_err);
        finish_cycle();

        // Drain: one word per cycle, in push order
        for (int i = 1; i <= DEPTH + 2; i++) begin
            drive_check(1'b0, '0, 1'b1, 1'b0);
            chk("drain_valid", POP_VALID_o, 1'b1);
            chk("drain_data", POP_DATA_o, i);
            finish_cycle();
        end
        drive_check(1'b0, '0, 1'b1, 1'b0);
        chk("drained_valid", POP_VALID_o, 1'b0);
        chk("drained_almost_empty", ALMOST_EMPTY_o, 1'b1);
        chk("err_held", ERR_o, exp_err);
        finish_cycle();
        step(1'b0, '0, 1'b0, 1'b1);
        drive_check(1'b0, '0, 1'b0, 1'b0);
        chk("err_cleared_by_flush", ERR_o, 1'b0);
        chk("flushed_count", COUNT_o, 0);
        finish_cycle();

        // Streaming push+pop every cycle; crosses the pointer wrap twice
        steady_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            drive_check(1'b1, DW'($urandom), 1'b1, 1'b0);
            if (i == 10) steady_cnt = m_total;
            if (i > 10) chk("stream_count_const", COUNT_o, steady_cnt);
            finish_cycle();
        end
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0);

        // Flush with a read in flight and five words held
        for (int i = 0; i < 5; i++) step(1'b1, DW'(18'h100 + i), 1'b0, 1'b0);
        step(1'b1, 18'h105, 1'b1, 1'b0);
        drive_check(1'b0, '0, 1'b0, 1'b1);
        chk("preflush_count", COUNT_o, 5);
        finish_cycle();
        drive_check(1'b0, '0, 1'b1, 1'b0);
        chk("postflush_count", COUNT_o, 0);
        chk("postflush_valid", POP_VALID_o, 1'b0);
        finish_cycle();
        for (int i = 0; i < 3; i++) begin
            drive_check(1'b0, '0, 1'b1, 1'b0);
            chk("flushed_word_absent", POP_VALID_o, 1'b0);
            finish_cycle();
        end
        step(1'b0, '0, 1'b0, 1'b1);

        // Randomized traffic with occasional flush
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 99) < 60, DW'($urandom), $urandom_range(0, 99) < 50,
                 $urandom_range(0, 199) == 0);
        end

        // Asynchronous reset mid-operation
        for (int i = 0; i < 4; i++) step(1'b1, DW'(18'h2000 + i), 1'b0, 1'b0);
        PUSH_VALID_i = 1'b0;
        POP_READY_i  = 1'b0;
        FLUSH_i      = 1'b0;
        RESET_ni     = 1'b0;
        #2;
        check_reset_values("async_reset");
        model_clear();
        #4 RESET_ni = 1'b1;
        finish_cycle();
        for (int i = 0; i < 6; i++) step(1'b1, DW'(18'h3000 + i), 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
